second_tick_uart_reporter: RTL and testbench
============================================

Name: second_tick_uart_reporter

Overview:
Downstream consumer of the one-second counter stage. On each one-cycle second tick it increments a BCD seconds count. It then transmits the count over the board UART_TX line as fixed-width ASCII decimal, followed by CR LF, using 8N1 framing. This gives a host-visible heartbeat in place of the LED-only indication.

Parameters:
CLOCK_Fre, 4000000, input clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLOCK_Fre/BAUD (integer truncation); DIV < 2 is an elaboration error
DIGITS, 4, number of BCD digits counted and sent; legal range 1..8

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick_i  input  1  one-cycle second pulse from the second counter
uart_tx  output  1  UART serial out; idles high
busy  output  1  frame in progress
sec_count  output  4*DIGITS  current BCD seconds count, most significant digit in the top nibble
overrun  output  1  sticky: a tick arrived while busy

Behaviour:
- Reset (async assert, sync release): uart_tx=1, busy=0, sec_count=0, overrun=0. The FSM goes to IDLE and all internal counters clear.
- Reset mid-frame aborts the frame immediately. No partial byte is resumed after release.
- BCD count:
  - A tick in cycle N increments sec_count; the new value is visible from N+1.
  - Each digit wraps 9->0 with carry to the next digit.
  - An all-9s count wraps to all-0s with no flag.
  - The count increments on every tick regardless of busy.
- Frame start:
  - If busy=0 in tick cycle N, the incremented value is snapshotted.
  - busy=1 and uart_tx=0 (start bit) from N+1.
- Tick while busy=1: the count still increments, overrun is set from N+1, and no frame is queued (drop).
  - overrun clears only on reset.
- Tick in the same cycle busy returns low: accepted as a new frame.
- FSM states IDLE, START, DATA, STOP; a char index runs 0..DIGITS+1.
  - START: 1 bit period, uart_tx=0.
  - DATA: 8 bit periods, LSB first.
  - STOP: 1 bit period, uart_tx=1.
  - Leaving STOP: go to START of the next char if chars remain, else IDLE.
- Bit period is exactly DIV clk cycles, from a baud counter 0..DIV-1 restarted at frame start. No drift is corrected.
- Characters, in order:
  - Snapshot digits MSD first as 0x30+digit; leading zeros are sent.
  - Then 0x0D, then 0x0A.
- Back-to-back chars: stop bit of char k is immediately followed by start bit of char k+1, with no idle gap.
- Frame length = (DIGITS+2)*10*DIV cycles.
  - busy is high for exactly that many cycles, then falls.
  - uart_tx remains 1 in IDLE.
- uart_tx is driven from a register, so it is glitch-free.

Test Plan:
(Bench uses CLOCK_Fre=1000, BAUD=100, so DIV=10, unless noted.)
1. Reset held, then released -> uart_tx=1, busy=0, sec_count=0, overrun=0; no toggling for 1000 cycles with tick_i=0.
2. DIGITS=4, single tick at cycle T:
   - sec_count=0x0001 at T+1; uart_tx=0 at T+1.
   - Decoded bytes are 0x30 0x30 0x30 0x31 0x0D 0x0A, each bit 10 cycles.
   - busy high exactly 600 cycles.
3. DIGITS=4, nine ticks spaced 700 cycles, then a tenth -> sec_count=0x0010; last frame "0010\r\n"; overrun=0.
4. DIGITS=2, count driven to 0x99 via ticks, then one tick -> sec_count=0x00; frame "00\r\n" (0x30 0x30 0x0D 0x0A).
5. DIGITS=4, tick, then a second tick 100 cycles later:
   - sec_count=0x0002, overrun=1, only one frame "0001\r\n".
   - A tick after busy falls sends "0003\r\n".
6. Reset asserted during char 2:
   - uart_tx=1, busy=0, sec_count=0 in the same cycle (async).
   - After release, a tick yields "0001\r\n".
   - Separately: a tick coincident with the busy-fall cycle starts a new frame with overrun unchanged.

Source files
------------

// File: rtl/second_tick_uart_reporter_if.sv
// Bundle between the second-tick source and the UART reporter.
// No latency of its own; it only carries signals between the two sides.
// No backpressure: tick_i is a pulse, and busy/overrun report what happened to it.
interface second_tick_uart_reporter_if #(
    parameter int DIGITS = 4
);
    logic                  tick_i;
    logic                  uart_tx;
    logic                  busy;
    logic [4*DIGITS-1:0]   sec_count;
    logic                  overrun;

    // tick source side
    modport master (
        output tick_i,
        input  uart_tx,
        input  busy,
        input  sec_count,
        input  overrun
    );

    // reporter side
    modport slave (
        input  tick_i,
        output uart_tx,
        output busy,
        output sec_count,
        output overrun
    );
endinterface

// File: rtl/second_tick_uart_reporter.sv
// Counts second ticks in BCD and sends each count as "DDDD\r\n" on an 8N1 UART.
// Latency: sec_count and start bit from the cycle after the tick; frame lasts (DIGITS+2)*10*DIV cycles.
// Backpressure: none; a tick while busy still counts, sets sticky overrun and drops the frame.
module second_tick_uart_reporter #(
    parameter int CLOCK_Fre = 4000000,
    parameter int BAUD      = 115200,
    parameter int DIGITS    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    second_tick_uart_reporter_if.slave    bus
);
    localparam int DIV = CLOCK_Fre / BAUD;
    localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(DIGITS + 2);
    localparam int NW  = 4 * DIGITS;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [CW-1:0] CHAR_LAST = CW'(DIGITS + 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("second_tick_uart_reporter: CLOCK_Fre/BAUD must be at least 2");
        end
        if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
            $error("second_tick_uart_reporter: DIGITS must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [CW-1:0]   char_q, char_d;
    logic [NW-1:0]   snap_q, snap_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic            ovr_q, ovr_d;
    logic            tx_q, tx_d;

    // BCD +1: each digit wraps 9->0 and carries; all-9s silently wraps to zero.
    function automatic logic [NW-1:0] bcd_inc(input logic [NW-1:0] v);
        logic [NW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Character at position idx: snapshot digits MSD first as ASCII, then CR, then LF.
    function automatic logic [7:0] char_byte(input logic [CW-1:0] idx, input logic [NW-1:0] snap);
        int i;
        i = int'(idx);
        if (i < DIGITS) begin
            return 8'h30 + {4'h0, snap[4*(DIGITS-1-i) +: 4]};
        end else if (i == DIGITS) begin
            return 8'h0D;
        end else begin
            return 8'h0A;
        end
    endfunction

    // Next-state, counters, BCD count and the registered serial bit.
    always_comb begin
        logic [NW-1:0] cnt_inc;
        logic [7:0]    tx_byte;
        logic          baud_last;

        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        char_d    = char_q;
        snap_d    = snap_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        tx_d      = 1'b1;
        tx_byte   = 8'h00;
        cnt_inc   = bcd_inc(cnt_q);
        baud_last = (baud_q == BAUD_LAST);

        if (bus.tick_i) begin
            cnt_d = cnt_inc;
            if (state_q != IDLE) begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.tick_i) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    char_d  = '0;
                    snap_d  = cnt_inc;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (char_q == CHAR_LAST) begin
                        state_d = IDLE;
                    end else begin
                        char_d  = char_q + 1'b1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level follows the state being entered, so uart_tx comes straight off a flop.
        case (state_d)
            START: tx_d = 1'b0;
            DATA: begin
                tx_byte = char_byte(char_d, snap_d);
                tx_d    = tx_byte[bit_d];
            end
            default: tx_d = 1'b1;
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            snap_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.uart_tx   = tx_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sec_count = cnt_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_second_tick_uart_reporter.sv
// Bench for the second-tick UART reporter with DIGITS=4 and DIGITS=2 instances.
// Expected frames are queued when ticks are driven and compared as the UART line is decoded.
// DIV=10 throughout (1000 Hz clock, 100 baud).
module tb_second_tick_uart_reporter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    second_tick_uart_reporter_if #(.DIGITS(4)) if4();
    second_tick_uart_reporter_if #(.DIGITS(2)) if2();

    second_tick_uart_reporter #(.CLOCK_Fre(1000), .BAUD(100), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave)
    );
    second_tick_uart_reporter #(.CLOCK_Fre(1000), .BAUD(100), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave)
    );

    int total = 0;
    int bad   = 0;
    int m4    = 0;
    int m2    = 0;
    logic [7:0] exp_q[$];

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function logic get_tx(input int d);
        return (d == 4) ? if4.uart_tx : if2.uart_tx;
    endfunction
    function logic get_busy(input int d);
        return (d == 4) ? if4.busy : if2.busy;
    endfunction
    function logic get_ovr(input int d);
        return (d == 4) ? if4.overrun : if2.overrun;
    endfunction
    function logic [31:0] get_cnt(input int d);
        return (d == 4) ? {16'h0, if4.sec_count} : {24'h0, if2.sec_count};
    endfunction

    task automatic set_tick(input int d, input logic v);
        if (d == 4) if4.tick_i = v;
        else        if2.tick_i = v;
    endtask

    task automatic push_frame(input int d, input int m);
        int p;
        p = 1;
        for (int i = 1; i < d; i++) p = p * 10;
        for (int i = 0; i < d; i++) begin
            exp_q.push_back(8'h30 + 8'((m / p) % 10));
            p = p / 10;
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_tick(4, 1'b0);
        set_tick(2, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m4 = 0;
        m2 = 0;
        exp_q.delete();
    endtask

    // Call right after a negedge: pulses tick for one cycle, then checks the next cycle.
    task automatic send_tick(input int d, input logic accept, input logic exp_ovr);
        int m;
        set_tick(d, 1'b1);
        if (d == 4) begin m4 = (m4 + 1) % 10000; m = m4; end
        else        begin m2 = (m2 + 1) % 100;   m = m2; end
        if (accept) push_frame(d, m);
        @(negedge clk);
        set_tick(d, 1'b0);
        total++;
        if (get_cnt(d) !== to_bcd(m)) begin
            bad++;
            $display("FAIL tick_count d=%0d got=%h want=%h", d, get_cnt(d), to_bcd(m));
        end
        if (accept) begin
            total++;
            if (get_busy(d) !== 1'b1 || get_tx(d) !== 1'b0) begin
                bad++;
                $display("FAIL frame_start d=%0d busy=%b tx=%b want busy=1 tx=0", d, get_busy(d), get_tx(d));
            end
        end
        total++;
        if (get_ovr(d) !== exp_ovr) begin
            bad++;
            $display("FAIL overrun d=%0d got=%b want=%b", d, get_ovr(d), exp_ovr);
        end
    endtask

    // Entered half a cycle into the start bit; decodes nchars chars at mid-bit,
    // checks busy lasts exactly the frame, optionally pulses one extra tick at cycle extra_at.
    task automatic rx_frame(input int d, input int nchars, input int extra_at);
        logic [9:0] sh;
        logic [7:0] want;
        int busy_bad;
        int ncyc;
        busy_bad = 0;
        sh = '0;
        ncyc = nchars * 100;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            set_tick(d, k == extra_at);
            if (get_busy(d) !== 1'b1) busy_bad++;
            if (k % 10 == 5) begin
                sh[(k / 10) % 10] = get_tx(d);
                if ((k / 10) % 10 == 9) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL rx_byte d=%0d got=%h with nothing expected", d, sh[8:1]);
                    end else begin
                        want = exp_q.pop_front();
                        if (sh !== {1'b1, want, 1'b0}) begin
                            bad++;
                            $display("FAIL rx_byte d=%0d got frame=%b want=%b", d, sh, {1'b1, want, 1'b0});
                        end
                    end
                end
            end
        end
        @(negedge clk);
        set_tick(d, 1'b0);
        total++;
        if (busy_bad != 0 || get_busy(d) !== 1'b0) begin
            bad++;
            $display("FAIL busy_len d=%0d low_cycles_inside=%0d busy_after=%b want 0/0", d, busy_bad, get_busy(d));
        end
        total++;
        if (exp_q.size() != 0 || get_tx(d) !== 1'b1) begin
            bad++;
            $display("FAIL frame_end d=%0d left_expected=%0d tx=%b want 0/1", d, exp_q.size(), get_tx(d));
        end
    endtask

    task automatic test_reset();
        int toggles;
        reset = 1'b1;
        if4.tick_i = 1'b0;
        if2.tick_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 2; d <= 4; d += 2) begin
            total++;
            if (get_tx(d) !== 1'b1 || get_busy(d) !== 1'b0 || get_cnt(d) !== 32'h0 || get_ovr(d) !== 1'b0) begin
                bad++;
                $display("FAIL reset_vals d=%0d tx=%b busy=%b cnt=%h ovr=%b want 1 0 0 0",
                         d, get_tx(d), get_busy(d), get_cnt(d), get_ovr(d));
            end
        end
        reset = 1'b0;
        toggles = 0;
        repeat (1000) begin
            @(negedge clk);
            if (if4.uart_tx !== 1'b1 || if4.busy !== 1'b0 || if2.uart_tx !== 1'b1 || if2.busy !== 1'b0)
                toggles++;
        end
        total++;
        if (toggles != 0 || get_cnt(4) !== 32'h0) begin
            bad++;
            $display("FAIL idle_quiet bad_cycles=%0d cnt=%h want 0 0", toggles, get_cnt(4));
        end
    endtask

    task automatic test_single_tick();
        apply_reset();
        send_tick(4, 1'b1, 1'b0);
        rx_frame(4, 6, -1);
    endtask

    task automatic test_digit_carry();
        apply_reset();
        for (int t = 0; t < 10; t++) begin
            send_tick(4, 1'b1, 1'b0);
            rx_frame(4, 6, -1);
            repeat (99) @(negedge clk);
        end
        total++;
        if (get_cnt(4) !== 32'h0010 || get_ovr(4) !== 1'b0) begin
            bad++;
            $display("FAIL carry_count cnt=%h ovr=%b want 0010 0", get_cnt(4), get_ovr(4));
        end
    endtask

    task automatic test_wrap();
        int waited;
        apply_reset();
        set_tick(2, 1'b1);
        repeat (99) @(negedge clk);
        set_tick(2, 1'b0);
        m2 = 99;
        waited = 0;
        while (if2.busy !== 1'b0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (waited >= 1000 || get_cnt(2) !== 32'h99) begin
            bad++;
            $display("FAIL wrap_pre waited=%0d cnt=%h want <1000 99", waited, get_cnt(2));
        end
        send_tick(2, 1'b1, 1'b1);
        rx_frame(2, 4, -1);
    endtask

    task automatic test_overrun();
        apply_reset();
        send_tick(4, 1'b1, 1'b0);
        m4 = m4 + 1;
        rx_frame(4, 6, 100);
        total++;
        if (get_cnt(4) !== 32'h0002 || get_ovr(4) !== 1'b1) begin
            bad++;
            $display("FAIL overrun_drop cnt=%h ovr=%b want 0002 1", get_cnt(4), get_ovr(4));
        end
        send_tick(4, 1'b1, 1'b1);
        rx_frame(4, 6, -1);
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        send_tick(4, 1'b1, 1'b0);
        repeat (205) @(negedge clk);
        total++;
        if (if4.uart_tx !== 1'b0 || if4.busy !== 1'b1) begin
            bad++;
            $display("FAIL char2_start tx=%b busy=%b want 0 1", if4.uart_tx, if4.busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (if4.uart_tx !== 1'b1 || if4.busy !== 1'b0 || if4.sec_count !== 16'h0) begin
            bad++;
            $display("FAIL async_reset tx=%b busy=%b cnt=%h want 1 0 0000", if4.uart_tx, if4.busy, if4.sec_count);
        end
        exp_q.delete();
        m4 = 0;
        m2 = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_tick(4, 1'b1, 1'b0);
        rx_frame(4, 6, -1);
    endtask

    task automatic test_back_to_back();
        // continues from the busy-fall cycle left by the previous frame
        send_tick(4, 1'b1, 1'b0);
        rx_frame(4, 6, -1);
    endtask

    initial begin
        test_reset();
        test_single_tick();
        test_digit_carry();
        test_wrap();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
